// File: rtl/exec_hazard_ctrl_if.sv
// Decode/Execute hazard bus between the pipeline datapath and exec_hazard_ctrl.
// master: the datapath. It drives the Decode instruction fields and the EX flags,
//         and receives the stall, flush and forward controls plus the EX/MEM tracking state.
// slave : exec_hazard_ctrl.
interface exec_hazard_ctrl_if #(parameter int REG_IDX_W = 5);
  logic                 id_valid;
  logic [REG_IDX_W-1:0] id_src1, id_src2, id_dest;
  logic                 id_use_src1, id_use_src2, id_writes;
  logic                 id_is_load, id_is_multi, id_is_branch;
  logic [1:0]           id_br_cond;
  logic                 ZF, GF, LF;
  logic                 stall_id, flush_id;
  logic [1:0]           fwd_sel1, fwd_sel2;
  logic                 ex_valid, mem_valid, busy;
  logic [REG_IDX_W-1:0] ex_dest, mem_dest;

  modport master (
    output id_valid, id_src1, id_src2, id_dest, id_use_src1, id_use_src2, id_writes,
           id_is_load, id_is_multi, id_is_branch, id_br_cond, ZF, GF, LF,
    input  stall_id, flush_id, fwd_sel1, fwd_sel2, ex_valid, ex_dest, mem_valid, mem_dest, busy
  );
  modport slave (
    input  id_valid, id_src1, id_src2, id_dest, id_use_src1, id_use_src2, id_writes,
           id_is_load, id_is_multi, id_is_branch, id_br_cond, ZF, GF, LF,
    output stall_id, flush_id, fwd_sel1, fwd_sel2, ex_valid, ex_dest, mem_valid, mem_dest, busy
  );
endinterface

// File: rtl/exec_hazard_ctrl.sv
// Decode->Execute issue sequencer for the 16-bit pipelined core.
// Tracks the EX and MEM destination registers and produces the operand forward selects.
// Inserts a one-cycle bubble on a load-use hazard.
// Holds the pipe while a multi-cycle op occupies EX.
// Flushes Decode when the branch in EX is taken.
// Ports: clk, reset (synchronous, active high), bus (exec_hazard_ctrl_if.slave).

// Hazard unit for one operand.
// The EX result is forwarded unless it comes from a load. A load-use hit is flagged separately.
module exec_hazard_fwd #(parameter int REG_IDX_W = 5) (
  input  logic [REG_IDX_W-1:0] src_i,
  input  logic                 use_i,
  input  logic                 ex_valid_i,
  input  logic                 ex_writes_i,
  input  logic                 ex_is_load_i,
  input  logic [REG_IDX_W-1:0] ex_dest_i,
  input  logic                 mem_valid_i,
  input  logic [REG_IDX_W-1:0] mem_dest_i,
  output logic [1:0]           fwd_o,
  output logic                 lu_hit_o
);
  logic nz, ex_hit, mem_hit;
  assign nz       = (src_i != '0);  // R0 is hardwired, never a hazard
  assign ex_hit   = use_i & nz & ex_valid_i & ex_writes_i & (src_i == ex_dest_i);
  assign mem_hit  = use_i & nz & mem_valid_i & (src_i == mem_dest_i);
  assign fwd_o    = (ex_hit & ~ex_is_load_i) ? 2'b01 : mem_hit ? 2'b10 : 2'b00;
  assign lu_hit_o = ex_hit & ex_is_load_i;
endmodule

module exec_hazard_ctrl #(
  parameter int MULTI_CYCLES = 4,
  parameter int REG_IDX_W    = 5
) (
  input logic             clk,
  input logic             reset,
  exec_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, LU_STALL, MULTI} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 ex_valid_q, ex_valid_d, ex_writes_q, ex_writes_d;
  logic                 ex_is_load_q, ex_is_load_d, ex_is_branch_q, ex_is_branch_d;
  logic [1:0]           ex_br_cond_q, ex_br_cond_d;
  logic [REG_IDX_W-1:0] ex_dest_q, ex_dest_d, mem_dest_q, mem_dest_d;
  logic                 mem_valid_q, mem_valid_d;

  logic [1:0][REG_IDX_W-1:0] src;
  logic [1:0]                use_src, lu_hit;
  logic [1:0][1:0]           fwd;

  assign src     = {bus.id_src2, bus.id_src1};
  assign use_src = {bus.id_use_src2, bus.id_use_src1};

  for (genvar g = 0; g < 2; g++) begin : g_op
    exec_hazard_fwd #(.REG_IDX_W(REG_IDX_W)) u_fwd (
      .src_i(src[g]), .use_i(use_src[g]),
      .ex_valid_i(ex_valid_q), .ex_writes_i(ex_writes_q), .ex_is_load_i(ex_is_load_q),
      .ex_dest_i(ex_dest_q), .mem_valid_i(mem_valid_q), .mem_dest_i(mem_dest_q),
      .fwd_o(fwd[g]), .lu_hit_o(lu_hit[g])
    );
  end

  logic flag_sel, branch_taken, load_use;
  always_comb begin
    case (ex_br_cond_q)
      2'b00:   flag_sel = bus.ZF;
      2'b01:   flag_sel = bus.GF;
      2'b10:   flag_sel = bus.LF;
      default: flag_sel = 1'b1;
    endcase
  end
  assign branch_taken = ex_valid_q & ex_is_branch_q & flag_sel;
  assign load_use     = bus.id_valid & (|lu_hit);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    busy_d         = busy_q;
    ex_valid_d     = 1'b0;          // bubble unless something issues
    ex_writes_d    = 1'b0;
    ex_is_load_d   = 1'b0;
    ex_is_branch_d = 1'b0;
    ex_br_cond_d   = 2'b00;
    ex_dest_d      = ex_dest_q;
    mem_valid_d    = ex_valid_q & ex_writes_q;
    mem_dest_d     = ex_dest_q;
    bus.stall_id   = 1'b0;
    bus.flush_id   = 1'b0;
    case (state_q)
      // LU_STALL behaves exactly like RUN: the load has moved on to MEM, so the re-evaluated
      // hazard checks now resolve through MEM forwarding.
      RUN, LU_STALL: begin
        state_d = RUN;
        if (branch_taken) begin
          bus.flush_id = 1'b1;
        end else if (load_use) begin
          bus.stall_id = 1'b1;
          state_d      = LU_STALL;
        end else if (bus.id_valid) begin
          ex_valid_d     = 1'b1;
          ex_writes_d    = bus.id_writes;
          ex_is_load_d   = bus.id_is_load;
          ex_is_branch_d = bus.id_is_branch;
          ex_br_cond_d   = bus.id_br_cond;
          ex_dest_d      = bus.id_dest;
          if (bus.id_is_multi) begin
            state_d = MULTI;
            cnt_d   = 4'(MULTI_CYCLES - 1);
            busy_d  = 1'b1;
          end
        end
      end
      MULTI: begin
        // EX is held; the cycle that sees cnt==1 is the last stalled one, and the op then
        // spends one more cycle in EX under RUN. That gives MULTI_CYCLES cycles of EX in total.
        bus.stall_id   = 1'b1;
        ex_valid_d     = ex_valid_q;
        ex_writes_d    = ex_writes_q;
        ex_is_load_d   = ex_is_load_q;
        ex_is_branch_d = ex_is_branch_q;
        ex_br_cond_d   = ex_br_cond_q;
        mem_valid_d    = 1'b0;
        mem_dest_d     = mem_dest_q;
        cnt_d          = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RUN;
          busy_d  = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      ex_valid_q     <= 1'b0;
      ex_writes_q    <= 1'b0;
      ex_is_load_q   <= 1'b0;
      ex_is_branch_q <= 1'b0;
      ex_br_cond_q   <= 2'b00;
      ex_dest_q      <= '0;
      mem_valid_q    <= 1'b0;
      mem_dest_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      busy_q         <= busy_d;
      ex_valid_q     <= ex_valid_d;
      ex_writes_q    <= ex_writes_d;
      ex_is_load_q   <= ex_is_load_d;
      ex_is_branch_q <= ex_is_branch_d;
      ex_br_cond_q   <= ex_br_cond_d;
      ex_dest_q      <= ex_dest_d;
      mem_valid_q    <= mem_valid_d;
      mem_dest_q     <= mem_dest_d;
    end
  end

  assign bus.fwd_sel1  = fwd[0];
  assign bus.fwd_sel2  = fwd[1];
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_dest   = ex_dest_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_dest  = mem_dest_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_exec_hazard_ctrl.sv
module tb_exec_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exec_hazard_ctrl_if #(.REG_IDX_W(5)) bus ();
  exec_hazard_ctrl #(.MULTI_CYCLES(4), .REG_IDX_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  localparam int F_STALL = 0, F_FLUSH = 1, F_FWD1 = 2, F_FWD2 = 3, F_EXV = 4,
                 F_EXD = 5, F_MEMV = 6, F_MEMD = 7, F_BUSY = 8;

  typedef struct { string tag; int f; logic [4:0] v; } exp_t;
  exp_t sb[$];
  int n_tests = 0, n_fail = 0;

  function automatic string fname(int f);
    case (f)
      F_STALL: return "stall_id";  F_FLUSH: return "flush_id";
      F_FWD1:  return "fwd_sel1";  F_FWD2:  return "fwd_sel2";
      F_EXV:   return "ex_valid";  F_EXD:   return "ex_dest";
      F_MEMV:  return "mem_valid"; F_MEMD:  return "mem_dest";
      default: return "busy";
    endcase
  endfunction

  function automatic logic [4:0] obs(int f);
    case (f)
      F_STALL: return {4'b0, bus.stall_id};
      F_FLUSH: return {4'b0, bus.flush_id};
      F_FWD1:  return {3'b0, bus.fwd_sel1};
      F_FWD2:  return {3'b0, bus.fwd_sel2};
      F_EXV:   return {4'b0, bus.ex_valid};
      F_EXD:   return bus.ex_dest;
      F_MEMV:  return {4'b0, bus.mem_valid};
      F_MEMD:  return bus.mem_dest;
      default: return {4'b0, bus.busy};
    endcase
  endfunction

  task automatic push(input string tag, input int f, input logic [4:0] v);
    exp_t e;
    e.tag = tag; e.f = f; e.v = v;
    sb.push_back(e);
  endtask

  // Sample mid-cycle, well away from the rising edge, then drain the scoreboard.
  task automatic chk();
    exp_t e;
    logic [4:0] got;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = obs(e.f);
      n_tests++;
      assert (got === e.v) else begin
        n_fail++;
        $error("FAIL %s/%s: got %0d expected %0d", e.tag, fname(e.f), got, e.v);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_src1 = 0; bus.id_src2 = 0; bus.id_dest = 0;
    bus.id_use_src1 = 0; bus.id_use_src2 = 0; bus.id_writes = 0;
    bus.id_is_load = 0; bus.id_is_multi = 0; bus.id_is_branch = 0; bus.id_br_cond = 0;
  endtask

  task automatic issue(input logic [4:0] d, s1, s2, input logic u1, u2, wr, ld, mu, br,
                       input logic [1:0] cond);
    bus.id_valid = 1; bus.id_dest = d; bus.id_src1 = s1; bus.id_src2 = s2;
    bus.id_use_src1 = u1; bus.id_use_src2 = u2; bus.id_writes = wr;
    bus.id_is_load = ld; bus.id_is_multi = mu; bus.id_is_branch = br; bus.id_br_cond = cond;
  endtask

  initial begin
    reset = 1; idle();
    bus.ZF = 0; bus.GF = 0; bus.LF = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // reset state
    for (int f = 0; f <= F_BUSY; f++) push("reset", f, 5'd0);
    chk();
    reset = 0;

    // forwarding: A writes R2
    issue(2, 1, 1, 1, 1, 1, 0, 0, 0, 0);
    push("fwdA", F_FWD1, 0); push("fwdA", F_STALL, 0); chk(); cyc();
    // B reads R2 while R2 is in EX
    issue(4, 2, 7, 1, 1, 1, 0, 0, 0, 0);
    push("fwdB", F_EXV, 1); push("fwdB", F_EXD, 2); push("fwdB", F_FWD1, 1); push("fwdB", F_FWD2, 0);
    chk(); cyc();
    // C: R2 only in MEM, R4 in EX
    issue(4, 2, 4, 1, 1, 1, 0, 0, 0, 0);
    push("fwdC", F_FWD1, 2); push("fwdC", F_FWD2, 1); push("fwdC", F_MEMV, 1); push("fwdC", F_MEMD, 2);
    chk(); cyc();
    // D: R4 in both EX and MEM -> EX wins
    issue(0, 4, 2, 1, 1, 0, 0, 0, 0, 0);
    push("fwdD", F_FWD1, 1); push("fwdD", F_FWD2, 0); push("fwdD", F_MEMD, 4); push("fwdD", F_EXD, 4);
    chk(); cyc();
    idle(); cyc(); cyc();

    // R0 and unused-source filters
    issue(0, 1, 1, 1, 1, 1, 0, 0, 0, 0); cyc();            // writes R0
    issue(5, 0, 0, 1, 1, 1, 0, 0, 0, 0);                   // reads R0, writes R5
    push("r0", F_EXV, 1); push("r0", F_FWD1, 0); push("r0", F_FWD2, 0); push("r0", F_STALL, 0);
    chk(); cyc();
    issue(6, 1, 5, 1, 0, 1, 0, 0, 0, 0);                   // src2=R5 but unused
    push("unused", F_EXD, 5); push("unused", F_FWD2, 0); push("unused", F_FWD1, 0);
    chk(); cyc();
    idle(); cyc(); cyc();

    // load-use
    issue(3, 1, 0, 1, 0, 1, 1, 0, 0, 0); cyc();            // LD R3
    issue(6, 3, 0, 1, 0, 1, 0, 0, 0, 0);
    push("lu0", F_STALL, 1); push("lu0", F_FWD1, 0); push("lu0", F_EXD, 3); chk(); cyc();
    push("lu1", F_STALL, 0); push("lu1", F_EXV, 0); push("lu1", F_FWD1, 2);
    push("lu1", F_MEMV, 1); push("lu1", F_MEMD, 3); chk(); cyc();
    idle();
    push("lu2", F_EXV, 1); push("lu2", F_EXD, 6); push("lu2", F_MEMV, 0); push("lu2", F_STALL, 0);
    chk(); cyc();
    cyc(); cyc();

    // multi-cycle op (4 cycles in EX)
    issue(7, 1, 0, 1, 0, 1, 0, 1, 0, 0);
    push("mc0", F_BUSY, 0); push("mc0", F_STALL, 0); chk(); cyc();
    issue(8, 7, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      push($sformatf("mc%0d", k), F_BUSY, 1); push($sformatf("mc%0d", k), F_STALL, 1);
      push($sformatf("mc%0d", k), F_EXV, 1);  push($sformatf("mc%0d", k), F_EXD, 7);
      push($sformatf("mc%0d", k), F_MEMV, 0);
      chk(); cyc();
    end
    push("mc4", F_BUSY, 0); push("mc4", F_STALL, 0); push("mc4", F_EXD, 7);
    push("mc4", F_MEMV, 0); push("mc4", F_FWD1, 1); chk(); cyc();
    idle();
    push("mc5", F_MEMV, 1); push("mc5", F_MEMD, 7); push("mc5", F_EXD, 8); chk(); cyc();
    cyc(); cyc();

    // branch taken on ZF
    issue(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00); cyc();
    issue(9, 1, 0, 1, 0, 1, 0, 0, 0, 0); bus.ZF = 1;
    push("brT", F_FLUSH, 1); push("brT", F_STALL, 0); chk(); cyc();
    idle(); bus.ZF = 0;
    push("brT+1", F_EXV, 0); push("brT+1", F_FLUSH, 0); chk(); cyc();
    // branch not taken, then an unconditional one
    issue(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00); cyc();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11);
    push("brN", F_FLUSH, 0); push("brN", F_EXV, 1); chk(); cyc();
    idle();
    push("brU", F_FLUSH, 1); chk(); cyc();
    push("brU+1", F_EXV, 0); chk(); cyc();

    // reset in the middle of a multi-cycle op
    issue(10, 0, 0, 0, 0, 1, 0, 1, 0, 0); cyc();
    idle(); cyc();
    push("rmc", F_BUSY, 1); chk();
    reset = 1; cyc(); reset = 0;
    push("rst", F_BUSY, 0); push("rst", F_EXV, 0); push("rst", F_MEMV, 0); push("rst", F_STALL, 0);
    issue(11, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk(); cyc();
    idle();
    push("rst+1", F_EXV, 1); push("rst+1", F_EXD, 11); push("rst+1", F_STALL, 0); chk(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
